// File: rtl/mapa_arbiter.sv
// rtl/mapa_arbiter.sv - round-robin arbiter for the map RAM port with (x,y) to linear address conversion
// Optional full-map clear sweep is enabled by defining MAPA_ARB_CLEAR_EN.
module mapa_arbiter #(
  parameter int MAPA_WIDTH  = 40,
  parameter int MAPA_HEIGHT = 30,
  parameter int ADDR_W      = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        req,
  input  logic [2:0]        we,
  input  logic [29:0]       x,
  input  logic [29:0]       y,
  input  logic [5:0]        wdata,
`ifdef MAPA_ARB_CLEAR_EN
  input  logic              clear_req,
  output logic              clear_busy,
`endif
  output logic [2:0]        gnt,
  output logic [2:0]        rvalid,
  output logic [1:0]        rdata,
  output logic [2:0]        err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [1:0]        mem_wdata,
  input  logic [1:0]        mem_rdata
);

  localparam logic [31:0] W32 = 32'(MAPA_WIDTH);
  localparam logic [31:0] H32 = 32'(MAPA_HEIGHT);
`ifdef MAPA_ARB_CLEAR_EN
  localparam logic [31:0] LAST_CELL = W32 * H32 - 32'd1;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
`ifdef MAPA_ARB_CLEAR_EN
    S_CLEAR = 2'd2,
`endif
    S_ISSUE = 2'd1
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          ptr_q, ptr_d;
  logic [1:0]          iss_id_q, iss_id_d;
  logic                iss_we_q, iss_we_d;
  logic                iss_oor_q, iss_oor_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          wdata_q, wdata_d;
  logic                s2_v_q, s2_v_d;
  logic [1:0]          s2_id_q, s2_id_d;
  logic                s2_blk_q, s2_blk_d;
  logic [2:0]          rvalid_q, rvalid_d;
  logic [1:0]          rdata_q, rdata_d;

  logic                arb_en;
  logic                hit;
  logic [1:0]          gnt_id;
  logic [2:0]          sum;
  logic [2:0]          gnt_c;
  logic [9:0]          sel_x, sel_y;
  logic                sel_we;
  logic [1:0]          sel_wd;
  logic                sel_oor;
  logic [ADDR_W-1:0]   addr_c;
  logic                issuing;

  function automatic logic [2:0] onehot(input logic [1:0] id);
    return 3'b001 << id;
  endfunction

  always_comb begin
    arb_en = !reset;
`ifdef MAPA_ARB_CLEAR_EN
    if (state_q == S_CLEAR || clear_req) arb_en = 1'b0;
`endif
    // Scan requesters starting at the pointer, wrapping modulo 3.
    hit    = 1'b0;
    gnt_id = 2'd0;
    sum    = 3'd0;
    for (int k = 0; k < 3; k++) begin
      sum = {1'b0, ptr_q} + 3'(k);
      if (sum >= 3'd3) sum = sum - 3'd3;
      if (arb_en && !hit && req[sum[1:0]]) begin
        hit    = 1'b1;
        gnt_id = sum[1:0];
      end
    end
    gnt_c = hit ? onehot(gnt_id) : 3'b000;

    case (gnt_id)
      2'd1: begin
        sel_x = x[19:10]; sel_y = y[19:10]; sel_we = we[1]; sel_wd = wdata[3:2];
      end
      2'd2: begin
        sel_x = x[29:20]; sel_y = y[29:20]; sel_we = we[2]; sel_wd = wdata[5:4];
      end
      default: begin
        sel_x = x[9:0];   sel_y = y[9:0];   sel_we = we[0]; sel_wd = wdata[1:0];
      end
    endcase
    sel_oor = ({22'd0, sel_x} >= W32) || ({22'd0, sel_y} >= H32);
    addr_c  = ADDR_W'({22'd0, sel_y} * W32 + {22'd0, sel_x});

    state_d   = hit ? S_ISSUE : S_IDLE;
    ptr_d     = hit ? ((gnt_id == 2'd2) ? 2'd0 : gnt_id + 2'd1) : ptr_q;
    iss_id_d  = gnt_id;
    iss_we_d  = sel_we;
    iss_oor_d = sel_oor;
    addr_d    = addr_c;
    wdata_d   = sel_wd;
`ifdef MAPA_ARB_CLEAR_EN
    // The sweep reuses the issue register: addr_q is the cell being cleared.
    if (state_q == S_CLEAR) begin
      if ({{(32-ADDR_W){1'b0}}, addr_q} == LAST_CELL) begin
        state_d = S_IDLE;
      end else begin
        state_d = S_CLEAR;
        addr_d  = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
      end
    end else if (clear_req) begin
      state_d = S_CLEAR;
      addr_d  = '0;
    end
`endif

    issuing  = (state_q == S_ISSUE);
    s2_v_d   = issuing && !iss_we_q;
    s2_id_d  = iss_id_q;
    s2_blk_d = iss_oor_q;
    rvalid_d = s2_v_q ? onehot(s2_id_q) : 3'b000;
    rdata_d  = s2_v_q ? (s2_blk_q ? 2'b11 : mem_rdata) : 2'b00;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ptr_q     <= 2'd0;
      iss_id_q  <= 2'd0;
      iss_we_q  <= 1'b0;
      iss_oor_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= 2'b00;
      s2_v_q    <= 1'b0;
      s2_id_q   <= 2'd0;
      s2_blk_q  <= 1'b0;
      rvalid_q  <= 3'b000;
      rdata_q   <= 2'b00;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      iss_id_q  <= iss_id_d;
      iss_we_q  <= iss_we_d;
      iss_oor_q <= iss_oor_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      s2_v_q    <= s2_v_d;
      s2_id_q   <= s2_id_d;
      s2_blk_q  <= s2_blk_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
    end
  end

  assign gnt    = gnt_c;
  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;
  assign err    = (issuing && iss_oor_q) ? onehot(iss_id_q) : 3'b000;

`ifdef MAPA_ARB_CLEAR_EN
  assign clear_busy = (state_q == S_CLEAR);
  assign mem_en     = (issuing && !iss_oor_q) || clear_busy;
  assign mem_we     = (issuing && !iss_oor_q && iss_we_q) || clear_busy;
  assign mem_wdata  = (issuing && !iss_oor_q && iss_we_q) ? wdata_q : 2'b00;
`else
  assign mem_en     = issuing && !iss_oor_q;
  assign mem_we     = issuing && !iss_oor_q && iss_we_q;
  assign mem_wdata  = mem_we ? wdata_q : 2'b00;
`endif
  assign mem_addr   = mem_en ? addr_q : '0;

endmodule

// File: tb/tb_mapa_arbiter.sv
// tb/tb_mapa_arbiter.sv - randomized scoreboard bench for mapa_arbiter
module tb_mapa_arbiter;
  localparam int W = 40;
  localparam int H = 30;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  req, we;
  logic [29:0] x, y;
  logic [5:0]  wdata;
  logic [2:0]  gnt, rvalid, err;
  logic [1:0]  rdata;
  logic        mem_en, mem_we;
  logic [10:0] mem_addr;
  logic [1:0]  mem_wdata;
  logic [1:0]  mem_rdata = 2'b00;

  mapa_arbiter dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .x(x), .y(y), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .err(err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Environment RAM: one-cycle registered read, writes land at the clock edge.
  logic [1:0] bram [2048] = '{default: 2'b00};
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) bram[mem_addr] <= mem_wdata;
      else        mem_rdata      <= bram[mem_addr];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct { int due; bit en; bit we; int addr; int wd; int err; } iss_t;
  typedef struct { int due; int id; int data; } rd_t;
  iss_t iq[$];
  rd_t  rq[$];
  iss_t ie;
  rd_t  re;

  // Reference model: map contents in grant order, round-robin pointer.
  logic [1:0] m_map [2048] = '{default: 2'b00};
  int m_ptr = 0;

  logic       p_req [3];
  logic       p_we  [3];
  logic [9:0] p_x   [3];
  logic [9:0] p_y   [3];
  logic [1:0] p_wd  [3];

  function automatic int pick(input logic [2:0] r, input int p);
    for (int k = 0; k < 3; k++) begin
      int i = (p + k) % 3;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic drive();
    req = '0; we = '0; x = '0; y = '0; wdata = '0;
    for (int i = 0; i < 3; i++) begin
      req[i] = p_req[i];
      we[i]  = p_we[i];
      x[10*i +: 10]    = p_x[i];
      y[10*i +: 10]    = p_y[i];
      wdata[2*i +: 2]  = p_wd[i];
    end
  endtask

  task automatic accept(input int w);
    int xi, yi, a;
    bit oor;
    iss_t e;
    rd_t r;
    xi = int'(p_x[w]);
    yi = int'(p_y[w]);
    oor = (xi >= W) || (yi >= H);
    a = yi * W + xi;
    e.due  = cyc + 1;
    e.en   = !oor;
    e.we   = p_we[w] && !oor;
    e.addr = a;
    e.wd   = int'(p_wd[w]);
    e.err  = oor ? (1 << w) : 0;
    iq.push_back(e);
    if (!p_we[w]) begin
      r.due  = cyc + 3;
      r.id   = w;
      r.data = oor ? 3 : int'(m_map[a]);
      rq.push_back(r);
    end else if (!oor) begin
      m_map[a] = p_wd[w];
    end
    m_ptr = (w + 1) % 3;
    p_req[w] = 1'b0;
  endtask

  task automatic run_cycle();
    int w;
    logic [2:0] eg;
    drive();
    @(negedge clk);
    w = pick(req, m_ptr);
    eg = (w < 0) ? 3'b000 : 3'(1 << w);
    check("gnt", 32'(gnt), 32'(eg));
    if (w >= 0) accept(w);
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input int i, input logic wr, input int xi, input int yi, input int wd);
    p_req[i] = 1'b1;
    p_we[i]  = wr;
    p_x[i]   = 10'(xi);
    p_y[i]   = 10'(yi);
    p_wd[i]  = 2'(wd);
  endtask

  task automatic do_cmd(input int i, input logic wr, input int xi, input int yi, input int wd);
    set_cmd(i, wr, xi, yi, wd);
    for (int n = 0; n < 20 && p_req[i]; n++) run_cycle();
    check("grant_timeout", 32'(p_req[i]), 0);
    p_req[i] = 1'b0;
  endtask

  task automatic rand_cmd(input int i);
    int r, xi, yi;
    r  = int'($urandom_range(0, 9));
    xi = (r < 8) ? int'($urandom_range(0, 3)) : ((r == 8) ? 39 : int'($urandom_range(40, 42)));
    r  = int'($urandom_range(0, 9));
    yi = (r < 8) ? int'($urandom_range(0, 2)) : ((r == 8) ? 29 : int'($urandom_range(30, 31)));
    set_cmd(i, 1'($urandom_range(0, 1)), xi, yi, int'($urandom_range(0, 3)));
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) p_req[i] = 1'b0;
    for (int n = 0; n < 16 && (iq.size() > 0 || rq.size() > 0); n++) run_cycle();
    check("drain_issue", iq.size(), 0);
    check("drain_read", rq.size(), 0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an issue, error or read completion.
  always @(negedge clk) begin
    if (reset) begin
      check("rst_gnt", 32'(gnt), 0);
      check("rst_rvalid", 32'(rvalid), 0);
      check("rst_rdata", 32'(rdata), 0);
      check("rst_err", 32'(err), 0);
      check("rst_mem_en", 32'(mem_en), 0);
      check("rst_mem_we", 32'(mem_we), 0);
      check("rst_mem_addr", 32'(mem_addr), 0);
      check("rst_mem_wdata", 32'(mem_wdata), 0);
    end else begin
      while (iq.size() > 0 && iq[0].due < cyc) begin
        check("issue_due", cyc, iq[0].due);
        void'(iq.pop_front());
      end
      if (mem_en || err != 3'b000) begin
        if (iq.size() > 0 && iq[0].due == cyc) begin
          ie = iq.pop_front();
          check("mem_en", 32'(mem_en), 32'(ie.en));
          check("err", 32'(err), ie.err);
          if (ie.en) begin
            check("mem_we", 32'(mem_we), 32'(ie.we));
            check("mem_addr", 32'(mem_addr), ie.addr);
          end
          if (ie.en && ie.we) check("mem_wdata", 32'(mem_wdata), ie.wd);
        end else begin
          check("issue_unexpected", {28'd0, err, mem_en}, 0);
        end
      end
      while (rq.size() > 0 && rq[0].due < cyc) begin
        check("rvalid_due", cyc, rq[0].due);
        void'(rq.pop_front());
      end
      if (rvalid != 3'b000) begin
        if (rq.size() > 0 && rq[0].due == cyc) begin
          re = rq.pop_front();
          check("rvalid", 32'(rvalid), 32'(1 << re.id));
          check("rdata", 32'(rdata), re.data);
        end else begin
          check("rvalid_unexpected", 32'(rvalid), 0);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      p_req[i] = 1'b0; p_we[i] = 1'b0; p_x[i] = '0; p_y[i] = '0; p_wd[i] = '0;
    end
    p_req[0] = 1'b1; p_req[1] = 1'b1; p_req[2] = 1'b1;
    drive();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    p_req[0] = 1'b0; p_req[1] = 1'b0; p_req[2] = 1'b0;

    // Single write to (10,10): address 410.
    do_cmd(0, 1'b1, 10, 10, 1);
    drain();

    // Everyone requesting every cycle: grants rotate through the pointer order.
    for (int n = 0; n < 9; n++) begin
      for (int i = 0; i < 3; i++)
        if (!p_req[i]) set_cmd(i, 1'b1, 20 + i, n, (n + i) % 4);
      run_cycle();
    end
    drain();

    // Write then read the same cell back to back.
    do_cmd(1, 1'b1, 15, 15, 2);
    do_cmd(1, 1'b0, 15, 15, 0);
    drain();

    // Out-of-range column: error pulse, no RAM access, blocked read returns 11.
    do_cmd(2, 1'b1, 40, 5, 3);
    do_cmd(2, 1'b0, 40, 5, 0);
    do_cmd(0, 1'b0, 2, 30, 0);
    drain();

    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < 3; i++)
        if (!p_req[i] && $urandom_range(0, 9) < 6) rand_cmd(i);
      run_cycle();
    end
    drain();

    // Reset one cycle after a read grant: the read is dropped and priority restarts at 0.
    do_cmd(1, 1'b0, 15, 15, 0);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) set_cmd(i, 1'b1, 5 + i, 7, i);
    drive();
    iq.delete();
    rq.delete();
    m_ptr = 0;
    @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    run_cycle();
    drain();
    repeat (4) run_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mapa_arbiter.md
Name: mapa_arbiter

Overview:
- Arbitrates the single port of the 2-bit-per-cell map RAM between three requesters: 0 = update FSM, 1 = fruit generator (reads to find free cells), 2 = obstacle writer.
- Round-robin grant, one command per cycle, in-order pipeline.
- Converts (x,y) to a linear address.
- Sits between the game-logic blocks and the map RAM, which is also read by the VGA side through its second port.

Parameters:
- MAPA_WIDTH, 40, map columns.
- MAPA_HEIGHT, 30, map rows.
- ADDR_W, 11, RAM address width; must satisfy 2^ADDR_W >= MAPA_WIDTH*MAPA_HEIGHT.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req  in  3  per-requester request; held until granted.
- we  in  3  per-requester write flag; 1 = write, 0 = read.
- x  in  30  packed column, requester i at bits [10i+9:10i].
- y  in  30  packed row, same packing as x.
- wdata  in  6  packed write data, requester i at bits [2i+1:2i].
- gnt  out  3  one-hot, one-cycle grant pulse.
- rvalid  out  3  one-hot, one-cycle read-data-valid pulse.
- rdata  out  2  read data; valid only when any rvalid bit is high.
- err  out  3  one-cycle pulse: granted command had x >= MAPA_WIDTH or y >= MAPA_HEIGHT.
- mem_en  out  1  RAM port enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_W  RAM address, y*MAPA_WIDTH + x.
- mem_wdata  out  2  RAM write data.
- mem_rdata  in  2  RAM read data; one-cycle registered latency after mem_en.

Behaviour:
- Reset: all outputs 0; round-robin pointer at requester 0, so requester 0 is highest priority; pipeline valid bits cleared; state IDLE.
  - Reset asserted mid-operation drops any in-flight read. No rvalid is issued for it.
- Arbitration (cycle G):
  - Combinational over req.
  - Priority order starts at pointer, e.g. pointer 1 gives 1, 2, 0.
  - At most one gnt bit is high.
  - When requester i is granted, pointer moves to (i+1) mod 3.
  - No request: pointer unchanged and gnt = 0.
- Requester rule: keep req, we, x, y and wdata stable until gnt is seen.
  - The requester may drop req or issue a new request in the cycle after gnt.
  - The same requester may be granted on consecutive cycles if it is the only one requesting.
- Command capture:
  - x, y, we and wdata of the granted requester are registered at the end of G.
  - mem_en, mem_we, mem_addr and mem_wdata are driven from these registers during G+1.
  - Address is computed as y*MAPA_WIDTH + x, truncated to ADDR_W.
- Out-of-range command:
  - gnt still pulses in G.
  - err[i] pulses in G+1.
  - mem_en stays 0 in G+1.
  - For a read, rvalid[i] pulses in G+3 with rdata = 2'b11, meaning blocked.
- Reads:
  - mem_rdata is valid in G+2 and is registered.
  - rvalid[i] and rdata appear in G+3.
  - A requester ID travels with the command through a 3-stage tag pipeline.
- Throughput and ordering:
  - One command per cycle; up to 3 commands in flight.
  - Commands complete in grant order.
  - A read granted after a write to the same cell returns the new value, because the RAM is write-before-read across cycles.
- Simultaneous events: requests from all three in one cycle produce grants over three consecutive cycles in pointer order.
- FSM:
  - IDLE: no command in the issue register.
  - ISSUE: command registered. ISSUE → ISSUE on back-to-back grants; ISSUE → IDLE when no grant.
  - CLEAR: exists only with the optional feature.

Optional Feature:
- Macro MAPA_ARB_CLEAR_EN.
- When defined, adds ports clear_req (in, 1) and clear_busy (out, 1).
- A clear_req pulse in IDLE or ISSUE enters CLEAR after the in-flight command issues:
  - gnt is held at 0 while in CLEAR.
  - The arbiter writes 2'b00 to addresses 0 to MAPA_WIDTH*MAPA_HEIGHT-1, one per cycle.
  - clear_busy is high from the cycle after clear_req until the last write has issued.
  - It then returns to IDLE; the pointer is unchanged.
  - clear_req during CLEAR is ignored.
- When undefined: no ports, no CLEAR state, no sweep logic.

Test Plan:
- Single write, req=3'b001, x0=10, y0=10, wdata0=01 → gnt=001 in G; mem_en=1, mem_we=1, mem_addr=410, mem_wdata=01 in G+1.
- All three requesting continuously from reset → gnt sequence 001, 010, 100, 001 on consecutive cycles.
- Requester 1 writes 10 to (15,15), then reads (15,15) on the next grant → rvalid=010 with rdata=10, 3 cycles after the read grant.
- Requester 2 issues x=40, y=5 → gnt=100, err=100 one cycle later, mem_en stays 0; the same command as a read gives rvalid=100 with rdata=11.
- Reset asserted one cycle after a read grant → all outputs 0 immediately; no rvalid follows; the next grant goes to requester 0 first.
- With MAPA_ARB_CLEAR_EN: pulse clear_req while req=3'b111 → clear_busy high for 1200 issue cycles, mem_addr steps 0 to 1199 with mem_wdata=00, gnt=0 throughout; grants resume afterwards from the saved pointer.
